univ_shift_reg: RTL and testbench

Parametrised universal shift register with asynchronous active-low reset. It supports parallel load, logical left/right shift, rotate and arithmetic right shift, and counts shifts since the last load. It is the general-purpose serialiser/deserialiser stage for datapath blocks. It replaces the fixed-width, left-shift-only register with a single block that any width or direction user can instantiate.

---
 rtl/univ_shift_reg.sv | 65 ++++++
 tb/tb_univ_shift_reg.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load, logical/rotate/arithmetic shifts,
// with a saturating count of shifts since the last load or reset.
module univ_shift_reg #(
    parameter  int DW = 8,
    localparam int CW = $clog2(DW + 1)
) (
    input  logic          clk,
    input  logic          async_rst_n,
    input  logic          load,
    input  logic          en,
    input  logic [2:0]    mode,
    input  logic [DW-1:0] data,
    input  logic          data_l,
    input  logic          data_r,
    output logic [DW-1:0] q,
    output logic          so_l,
    output logic          so_r,
    output logic [CW-1:0] cnt,
    output logic          done
);

    localparam logic [2:0] MODE_SHL = 3'b000;
    localparam logic [2:0] MODE_SHR = 3'b001;
    localparam logic [2:0] MODE_ROL = 3'b010;
    localparam logic [2:0] MODE_ROR = 3'b011;
    localparam logic [2:0] MODE_ASR = 3'b100;

    localparam logic [CW-1:0] CNT_MAX = CW'(DW);

    logic [DW-1:0] q_shift;
    logic          mode_valid;

    always_comb begin
        q_shift    = q;
        mode_valid = 1'b1;
        case (mode)
            MODE_SHL: q_shift = {q[DW-2:0], data_l};
            MODE_SHR: q_shift = {data_r, q[DW-1:1]};
            MODE_ROL: q_shift = {q[DW-2:0], q[DW-1]};
            MODE_ROR: q_shift = {q[0], q[DW-1:1]};
            MODE_ASR: q_shift = {q[DW-1], q[DW-1:1]};
            default:  mode_valid = 1'b0;
        endcase
    end

    // Reserved modes behave exactly like en=0: neither q nor cnt moves.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            q   <= '0;
            cnt <= '0;
        end else if (load) begin
            q   <= data;
            cnt <= '0;
        end else if (en && mode_valid) begin
            q <= q_shift;
            if (cnt < CNT_MAX)
                cnt <= cnt + CW'(1);
        end
    end

    assign so_l = q[DW-1];
    assign so_r = q[0];
    assign done = (cnt == CNT_MAX);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (DW=4): directed scenarios followed by
// randomized traffic, all checked against an arithmetic reference model.
module tb_univ_shift_reg;

    localparam int DW = 4;
    localparam int CW = $clog2(DW + 1);
    localparam int MOD = 1 << DW;
    localparam int MSB_W = 1 << (DW - 1);

    logic          clk = 1'b0;
    logic          async_rst_n;
    logic          load;
    logic          en;
    logic [2:0]    mode;
    logic [DW-1:0] data;
    logic          data_l;
    logic          data_r;
    logic [DW-1:0] q;
    logic          so_l;
    logic          so_r;
    logic [CW-1:0] cnt;
    logic          done;

    int n_cmp = 0;
    int n_err = 0;
    int m_q   = 0;
    int m_cnt = 0;

    always #5 clk = ~clk;

    univ_shift_reg #(.DW(DW)) dut (
        .clk         (clk),
        .async_rst_n (async_rst_n),
        .load        (load),
        .en          (en),
        .mode        (mode),
        .data        (data),
        .data_l      (data_l),
        .data_r      (data_r),
        .q           (q),
        .so_l        (so_l),
        .so_r        (so_r),
        .cnt         (cnt),
        .done        (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".q"},    32'(q),    32'(m_q));
        chk({tag, ".cnt"},  32'(cnt),  32'(m_cnt));
        chk({tag, ".done"}, 32'(done), 32'(m_cnt == DW));
        chk({tag, ".so_l"}, 32'(so_l), 32'(m_q / MSB_W));
        chk({tag, ".so_r"}, 32'(so_r), 32'(m_q % 2));
    endtask

    // Reference: what one rising edge does, computed with plain arithmetic.
    task automatic model_edge();
        int nq;
        if (!async_rst_n) begin
            m_q = 0; m_cnt = 0;
        end else if (load) begin
            m_q = int'(data); m_cnt = 0;
        end else if (en && mode <= 3'd4) begin
            case (mode)
                3'd0:    nq = (m_q * 2 + int'(data_l)) % MOD;
                3'd1:    nq = m_q / 2 + int'(data_r) * MSB_W;
                3'd2:    nq = (m_q * 2) % MOD + m_q / MSB_W;
                3'd3:    nq = m_q / 2 + (m_q % 2) * MSB_W;
                default: nq = m_q / 2 + ((m_q >= MSB_W) ? MSB_W : 0);
            endcase
            m_q = nq;
            if (m_cnt < DW) m_cnt = m_cnt + 1;
        end
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_load(input int v);
        load = 1'b1; en = 1'b0; data = DW'(v);
        step("load");
        load = 1'b0;
    endtask

    task automatic shift(input int md, input int dl, input int dr, input string tag);
        en = 1'b1; mode = 3'(md); data_l = 1'(dl); data_r = 1'(dr);
        step(tag);
    endtask

    initial begin
        async_rst_n = 1'b0;
        load = 1'b0; en = 1'b0; mode = 3'd0; data = '0; data_l = 1'b0; data_r = 1'b0;
        #1;
        check_all("reset");
        #11 async_rst_n = 1'b1;
        step("post_reset_hold");

        // SHL serialise
        do_load(4'b1011);
        shift(0, 1, 0, "shl1"); chk("shl1.q_lit", 32'(q), 32'b0111);
        shift(0, 0, 0, "shl2"); chk("shl2.q_lit", 32'(q), 32'b1110);
        shift(0, 1, 0, "shl3"); chk("shl3.q_lit", 32'(q), 32'b1101);
        shift(0, 1, 0, "shl4"); chk("shl4.q_lit", 32'(q), 32'b1011);
        chk("shl4.done_lit", 32'(done), 32'd1);

        // ROR through saturation
        do_load(4'b1001);
        for (int i = 0; i < 5; i++) shift(3, 1, 1, "ror");
        chk("ror5.q_lit",   32'(q),   32'b1100);
        chk("ror5.cnt_lit", 32'(cnt), 32'd4);

        // ASR then SHR
        do_load(4'b1000);
        for (int i = 0; i < 3; i++) shift(4, 0, 0, "asr");
        chk("asr3.q_lit", 32'(q), 32'b1111);
        do_load(4'b1000);
        for (int i = 0; i < 2; i++) shift(1, 1, 0, "shr");
        chk("shr2.q_lit", 32'(q), 32'b0010);

        // Async reset between edges
        do_load(4'b1010);
        shift(2, 0, 0, "rol_a"); shift(2, 0, 0, "rol_b");
        en = 1'b0;
        #2 async_rst_n = 1'b0;
        #1;
        m_q = 0; m_cnt = 0;
        check_all("async_rst");
        en = 1'b1; load = 1'b1; data = 4'b1111;
        step("rst_hold1");
        step("rst_hold2");
        load = 1'b0; en = 1'b0;
        #2 async_rst_n = 1'b1;

        // Load beats enable on the same edge
        do_load(4'b1100);
        for (int i = 0; i < 3; i++) shift(2, 0, 0, "rol_c");
        load = 1'b1; en = 1'b1; mode = 3'd0; data = 4'b0011;
        step("collision");
        chk("collision.q_lit", 32'(q), 32'b0011);
        load = 1'b0;

        // Reserved mode and en=0 hold
        do_load(4'b1010);
        shift(2, 0, 0, "rol_d");
        shift(6, 1, 1, "rsv1");
        shift(6, 1, 1, "rsv2");
        chk("rsv.q_lit", 32'(q), 32'b0101);
        en = 1'b0; mode = 3'd0;
        step("hold");

        // Randomized traffic, with occasional mid-cycle resets
        for (int i = 0; i < 600; i++) begin
            load   = ($urandom_range(0, 7) == 0);
            en     = ($urandom_range(0, 3) != 0);
            mode   = 3'($urandom_range(0, 7));
            data   = DW'($urandom);
            data_l = 1'($urandom);
            data_r = 1'($urandom);
            if ($urandom_range(0, 59) == 0) begin
                #2 async_rst_n = 1'b0;
                #1;
                m_q = 0; m_cnt = 0;
                check_all("rnd_async_rst");
                #2 async_rst_n = 1'b1;
            end
            step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
